// File: rtl/cache_pkg.sv
// Shared types for the L1 refill/write-back arbiter: arbiter states, requester ids
// and the bus word size.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        I_FILL,
        D_READ,
        D_WRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Next-level memory port: one outstanding single-word beat, request held until acknowledged.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/cache_beat_ctr.sv
// Beat index within a cache block: clear wins over increment, wraps naturally at B-1.
module cache_beat_ctr #(
    parameter int B = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear,
    input  logic                 incr,
    output logic [$clog2(B)-1:0] beat,
    output logic                 last_beat
);
    localparam int BW = $clog2(B);

    logic [BW-1:0] beat_reg;
    logic [BW-1:0] beat_next;

    always_comb begin
        beat_next = beat_reg;
        if (clear) begin
            beat_next = '0;
        end else if (incr) begin
            beat_next = beat_reg + BW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_reg <= '0;
        end else begin
            beat_reg <= beat_next;
        end
    end

    assign beat      = beat_reg;
    assign last_beat = (beat_reg == BW'(B - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one next-level memory port between I-cache refills and D-cache refills/write-backs,
// moving each block as B single-word beats and steering beats back to the owning cache.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int B      = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,

    input  logic                 ic_req_i,
    input  logic [ADDR_W-1:0]    ic_addr_i,
    input  logic                 ic_abort_i,

    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [ADDR_W-1:0]    dc_addr_i,
    input  logic [DATA_W-1:0]    dc_wdata_i,

    cache_mem_arbiter_if.master  mem,

    output logic [DATA_W-1:0]    fill_rdata_o,
    output logic                 ic_beat_valid_o,
    output logic                 dc_beat_valid_o,
    output logic [$clog2(B)-1:0] ic_beat_idx_o,
    output logic [$clog2(B)-1:0] dc_beat_idx_o,
    output logic                 ic_done_o,
    output logic                 dc_done_o,
    output logic                 busy_o
);
    localparam int BW  = $clog2(B);
    localparam int OFF = BW + $clog2(WORD_BYTES);

    arb_state_t  state_reg, state_next;
    requester_t  last_served_reg;
    logic        last_dwrite_reg;
    logic        abort_pend_reg;
    logic        ic_done_reg, dc_done_reg;
    logic [ADDR_W-1:0] base_reg;

    logic [BW-1:0] beat;
    logic          last_beat;
    logic          grant_i, grant_d;
    logic          in_transfer, in_dcache, beat_ack, abort_now, finish;

    assign in_transfer = (state_reg == I_FILL) || (state_reg == D_READ) || (state_reg == D_WRITE);
    assign in_dcache   = (state_reg == D_READ) || (state_reg == D_WRITE);
    assign beat_ack    = in_transfer && mem.ack;
    // An abort raised on the same cycle as an ack terminates on that very ack.
    assign abort_now   = (state_reg == I_FILL) && (abort_pend_reg || ic_abort_i);
    assign finish      = beat_ack && (last_beat || abort_now);

    always_comb begin
        state_next = state_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state_reg)
            IDLE: begin
                // A write-back locks the port for the D-cache so the refill follows at once.
                if (dc_req_i && (!ic_req_i || last_dwrite_reg || last_served_reg == REQ_I)) begin
                    grant_d    = 1'b1;
                    state_next = dc_we_i ? D_WRITE : D_READ;
                end else if (ic_req_i) begin
                    grant_i    = 1'b1;
                    state_next = I_FILL;
                end
            end
            I_FILL, D_READ, D_WRITE: begin
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= IDLE;
            last_served_reg <= REQ_D;
            last_dwrite_reg <= 1'b0;
            abort_pend_reg  <= 1'b0;
            ic_done_reg     <= 1'b0;
            dc_done_reg     <= 1'b0;
            base_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            abort_pend_reg <= (state_next == I_FILL) && (state_reg == I_FILL)
                              && (abort_pend_reg || ic_abort_i);
            ic_done_reg    <= finish && (state_reg == I_FILL) && !abort_now;
            dc_done_reg    <= finish && in_dcache;
            if (grant_i) begin
                base_reg        <= {ic_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                last_served_reg <= REQ_I;
            end
            if (grant_d) begin
                base_reg        <= {dc_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                last_served_reg <= REQ_D;
            end
            if (finish) begin
                last_dwrite_reg <= (state_reg == D_WRITE);
            end
        end
    end

    // Clearing on finish also rewinds a block cut short by an abort.
    cache_beat_ctr #(.B(B)) u_beat_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear     (grant_i || grant_d || finish),
        .incr      (beat_ack),
        .beat      (beat),
        .last_beat (last_beat)
    );

    assign mem.req   = in_transfer;
    assign mem.we    = (state_reg == D_WRITE);
    assign mem.addr  = in_transfer ? (base_reg + (ADDR_W'(beat) << $clog2(WORD_BYTES))) : '0;
    assign mem.wdata = (state_reg == D_WRITE) ? dc_wdata_i : '0;

    assign fill_rdata_o    = mem.rdata;
    assign ic_beat_valid_o = (state_reg == I_FILL) && mem.ack;
    assign dc_beat_valid_o = in_dcache && mem.ack;
    assign ic_beat_idx_o   = (state_reg == I_FILL) ? beat : '0;
    assign dc_beat_idx_o   = in_dcache ? beat : '0;
    assign ic_done_o       = ic_done_reg;
    assign dc_done_o       = dc_done_reg;
    assign busy_o          = (state_reg != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a beat scoreboard filled at stimulus time and
// drained by a memory-side monitor, plus directed checks on done, abort and reset.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        ic_req = 1'b0, ic_abort = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        dc_req = 1'b0, dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata;
    logic        ack_r = 1'b1;

    logic [31:0] fill_rdata;
    logic        ic_beat_valid, dc_beat_valid, ic_done, dc_done, busy;
    logic [3:0]  ic_beat_idx, dc_beat_idx;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        own_d;
        logic [3:0]  idx;
    } beat_t;
    beat_t sb[$];

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    assign mem.ack   = ack_r;
    assign mem.rdata = {mem.addr[15:0], ~mem.addr[15:0]};
    assign dc_wdata  = 32'hDA7A_0000 + 32'(dc_beat_idx) * 32'd17;

    cache_mem_arbiter #(.B(16), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .ic_req_i        (ic_req),
        .ic_addr_i       (ic_addr),
        .ic_abort_i      (ic_abort),
        .dc_req_i        (dc_req),
        .dc_we_i         (dc_we),
        .dc_addr_i       (dc_addr),
        .dc_wdata_i      (dc_wdata),
        .mem             (mem),
        .fill_rdata_o    (fill_rdata),
        .ic_beat_valid_o (ic_beat_valid),
        .dc_beat_valid_o (dc_beat_valid),
        .ic_beat_idx_o   (ic_beat_idx),
        .dc_beat_idx_o   (dc_beat_idx),
        .ic_done_o       (ic_done),
        .dc_done_o       (dc_done),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic own_d, input logic we, input logic [31:0] addr,
                            input int nbeats);
        logic [31:0] base;
        base = addr & ~32'h3F;
        for (int i = 0; i < nbeats; i++) begin
            beat_t e;
            e.addr  = base + 32'(i) * 32'd4;
            e.we    = we;
            e.wdata = we ? 32'hDA7A_0000 + 32'(i) * 32'd17 : 32'h0;
            e.own_d = own_d;
            e.idx   = 4'(i);
            sb.push_back(e);
        end
    endtask

    // Waits for the next done pulse; cycles counts ticks taken.
    task automatic wait_done(input string tag, input logic want_d, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(ic_done || dc_done) && cycles < 200);
        check({tag, "_done"},  want_d ? dc_done : ic_done, 1'b1);
        check({tag, "_other"}, want_d ? ic_done : dc_done, 1'b0);
        $display("txn %s: done after %0d cycles", tag, cycles);
    endtask

    // Memory-side monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset_i && mem.req && mem.ack) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_addr",  mem.addr,  e.addr);
                check("beat_we",    mem.we,    e.we);
                check("beat_wdata", mem.wdata, e.wdata);
                check("beat_ivld",  ic_beat_valid, !e.own_d);
                check("beat_dvld",  dc_beat_valid, e.own_d);
                check("beat_idx",   e.own_d ? dc_beat_idx : ic_beat_idx, e.idx);
                check("beat_rdata", fill_rdata, {e.addr[15:0], ~e.addr[15:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  found;

        // Reset, then the idle state with ack held high (ack must be ignored).
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        check("rst_busy",   busy, 1'b0);
        check("rst_req",    mem.req, 1'b0);
        check("rst_we",     mem.we, 1'b0);
        check("rst_addr",   mem.addr, 32'h0);
        check("rst_wdata",  mem.wdata, 32'h0);
        check("rst_valid",  {ic_beat_valid, dc_beat_valid}, 2'b00);
        check("rst_done",   {ic_done, dc_done}, 2'b00);
        check("rst_idx",    {ic_beat_idx, dc_beat_idx}, 8'h00);

        // I refill alone, zero-wait memory.
        ic_addr = 32'h0000_1234;
        ic_req  = 1'b1;
        push_txn(1'b0, 1'b0, 32'h0000_1234, 16);
        tick();
        check("grant_latency", mem.req, 1'b1);
        wait_done("i_alone", 1'b0, cyc);
        check("i_alone_done_cycle", cyc + 1, 17);
        ic_req = 1'b0;
        tick();
        check("i_alone_idle", busy, 1'b0);

        // Tie after reset: I first; I re-requests and loses to D; then I again.
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();
        ic_addr = 32'h0000_1000;
        dc_addr = 32'h0000_3000;
        dc_we   = 1'b0;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        push_txn(1'b0, 1'b0, 32'h0000_1000, 16);
        push_txn(1'b1, 1'b0, 32'h0000_3000, 16);
        push_txn(1'b0, 1'b0, 32'h0000_5000, 16);
        wait_done("tie_i", 1'b0, cyc);
        ic_req = 1'b0;
        tick();
        check("tie_gap_idle", busy, 1'b0);
        ic_addr = 32'h0000_5000;
        ic_req  = 1'b1;
        wait_done("tie_d", 1'b1, cyc);
        dc_req = 1'b0;
        wait_done("tie_i2", 1'b0, cyc);
        ic_req = 1'b0;
        tick();

        // Write-back then its refill, with I also waiting: D_WRITE, D_READ, I_FILL.
        dc_addr = 32'h0000_8040;
        dc_we   = 1'b1;
        dc_req  = 1'b1;
        ic_addr = 32'h0000_2FFF;
        ic_req  = 1'b1;
        push_txn(1'b1, 1'b1, 32'h0000_8040, 16);
        push_txn(1'b1, 1'b0, 32'h0000_4A7C, 16);
        push_txn(1'b0, 1'b0, 32'h0000_2FFF, 16);
        wait_done("wb", 1'b1, cyc);
        dc_we   = 1'b0;
        dc_addr = 32'h0000_4A7C;
        wait_done("wb_refill", 1'b1, cyc);
        dc_req = 1'b0;
        wait_done("wb_ifill", 1'b0, cyc);
        ic_req = 1'b0;
        tick();

        // Abort at beat 5 while memory stalls that beat for 3 cycles.
        ic_addr = 32'h0000_7010;
        ic_req  = 1'b1;
        push_txn(1'b0, 1'b0, 32'h0000_7010, 6);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (mem.req && ic_beat_idx == 4'd5) found = 1'b1;
        end
        check("abort_reach_beat5", found, 1'b1);
        ack_r    = 1'b0;
        ic_abort = 1'b1;
        tick();
        ic_abort = 1'b0;
        ic_req   = 1'b0;
        check("abort_stall_req1", mem.req, 1'b1);
        tick();
        check("abort_stall_req2", mem.req, 1'b1);
        tick();
        check("abort_stall_req3", mem.req, 1'b1);
        ack_r = 1'b1;
        tick();
        check("abort_done_state", {busy, mem.req}, 2'b10);
        check("abort_no_done", {ic_done, dc_done}, 2'b00);
        tick();
        check("abort_idle", busy, 1'b0);
        $display("txn abort: terminated after beat 5");
        ic_addr = 32'h0000_9000;
        ic_req  = 1'b1;
        push_txn(1'b0, 1'b0, 32'h0000_9000, 16);
        wait_done("post_abort", 1'b0, cyc);
        ic_req = 1'b0;
        tick();

        // Reset at beat 7 of a D refill.
        dc_addr = 32'h0000_6000;
        dc_we   = 1'b0;
        dc_req  = 1'b1;
        push_txn(1'b1, 1'b0, 32'h0000_6000, 7);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (mem.req && dc_beat_idx == 4'd7) found = 1'b1;
        end
        check("reset_reach_beat7", found, 1'b1);
        reset_i = 1'b1;
        tick();
        check("midrst_busy", busy, 1'b0);
        check("midrst_req",  mem.req, 1'b0);
        check("midrst_done", dc_done, 1'b0);
        reset_i = 1'b0;
        dc_req  = 1'b0;
        tick();
        $display("txn reset: D refill cut at beat 7");
        dc_req = 1'b1;
        push_txn(1'b1, 1'b0, 32'h0000_6000, 16);
        wait_done("post_reset", 1'b1, cyc);
        dc_req = 1'b0;
        tick();
        tick();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
